brew_order_scheduler: RTL and testbench

- Queues coffee orders (type 0/1/2) from the selection front-end in a small FIFO.
- Dispatches orders one at a time to the brewing FSM using a start/done handshake.
- Enforces a cool-down gap between brews and a watchdog timeout on each brew.
- Sits between the debounced button logic and the brewing FSM; reports queue depth, busy status, fault status and a served-cup count to the display/LED logic.

---
 rtl/brew_order_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_brew_order_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brew_order_scheduler.sv
// -----------------------------------------------------------------------------
// brew_order_scheduler
//
// Purpose:
//   Queues coffee orders from the selection front-end in a small FIFO and
//   dispatches them one at a time to the brewing FSM with a start/done
//   handshake. A cool-down gap follows every completed brew, and a watchdog
//   moves the scheduler to FAULT when a brew never reports completion.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   order_valid   in   single-cycle order request
//   order_type    in   coffee type 0..2 (3 is illegal)
//   cancel_all    in   single-cycle pulse, flushes the queue
//   clear_fault   in   single-cycle pulse, leaves FAULT
//   brew_done     in   single-cycle completion pulse from the brewer
//   order_accept  out  one-cycle pulse, order was stored
//   order_reject  out  one-cycle pulse, order was dropped
//   brew_start    out  one-cycle start pulse to the brewer
//   brew_type     out  type of the current / last dispatched brew
//   brew_busy     out  high while issuing or brewing
//   fault         out  high in FAULT
//   queue_count   out  occupied FIFO entries
//   served_count  out  completed brews, wraps at 255
// -----------------------------------------------------------------------------
module brew_order_scheduler #(
   parameter int DEPTH          = 4,
   parameter int GAP_CYCLES     = 50000000,
   parameter int TIMEOUT_CYCLES = 1500000000,
   parameter int TIMER_W        = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     order_valid,
   input  logic [1:0]               order_type,
   input  logic                     cancel_all,
   input  logic                     clear_fault,
   input  logic                     brew_done,
   output logic                     order_accept,
   output logic                     order_reject,
   output logic                     brew_start,
   output logic [1:0]               brew_type,
   output logic                     brew_busy,
   output logic                     fault,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic [7:0]               served_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]      COUNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0]      COUNT_FULL   = CW'(DEPTH);
   localparam logic [AW-1:0]      PTR_ZERO     = {AW{1'b0}};
   localparam logic [AW-1:0]      PTR_ONE      = AW'(1);
   localparam logic [1:0]         TYPE_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_BREWING = 3'd2,
      ST_GAP     = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   // Pointer advance; DEPTH is a power of two so natural wrap is correct.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return ptr + PTR_ONE;
   endfunction

   state_t               state_r;
   state_t               state_next;
   logic [TIMER_W-1:0]   timer_r;
   logic [TIMER_W-1:0]   timer_next;

   logic [1:0]           fifo_mem [DEPTH];
   logic [AW-1:0]        head_r;
   logic [AW-1:0]        tail_r;
   logic [CW-1:0]        count_r;
   logic [CW-1:0]        count_next;

   logic                 pop_s;
   logic                 push_ok_s;
   logic                 full_s;
   logic                 start_s;
   logic                 served_inc_s;

   logic                 order_accept_r;
   logic                 order_reject_r;
   logic                 brew_start_r;
   logic [1:0]           brew_type_r;
   logic                 brew_busy_r;
   logic                 fault_r;
   logic [7:0]           served_r;

   assign full_s = (count_r == COUNT_FULL);

   // Next-state, timer and dispatch decisions for the brew sequencer.
   always_comb begin
      state_next   = state_r;
      timer_next   = timer_r;
      pop_s        = 1'b0;
      start_s      = 1'b0;
      served_inc_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A flush on this edge wins over dispatching the head entry.
            if ((count_r != COUNT_ZERO) && !cancel_all) begin
               pop_s      = 1'b1;
               state_next = ST_ISSUE;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            start_s    = 1'b1;
            timer_next = TIMER_ZERO;
            state_next = ST_BREWING;
         end
         ST_BREWING: begin
            // Completion is checked first so a done on the timeout cycle counts.
            if (brew_done) begin
               served_inc_s = 1'b1;
               timer_next   = TIMER_ZERO;
               state_next   = ST_GAP;
            end else if (timer_r == TIMEOUT_LAST) begin
               timer_next   = TIMER_ZERO;
               state_next   = ST_FAULT;
            end else begin
               timer_next   = timer_r + TIMER_ONE;
               state_next   = ST_BREWING;
            end
         end
         ST_GAP: begin
            if (timer_r == GAP_LAST) begin
               timer_next = TIMER_ZERO;
               state_next = ST_IDLE;
            end else begin
               timer_next = timer_r + TIMER_ONE;
               state_next = ST_GAP;
            end
         end
         ST_FAULT: begin
            if (clear_fault) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_FAULT;
            end
         end
         default: begin
            timer_next = TIMER_ZERO;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Push acceptance and occupancy update; a pop frees a slot on the same edge.
   always_comb begin
      push_ok_s  = order_valid && (order_type != TYPE_ILLEGAL) && !cancel_all
                   && (!full_s || pop_s);
      count_next = count_r;
      if (cancel_all) begin
         count_next = COUNT_ZERO;
      end else begin
         count_next = count_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_s};
      end
   end

   // FSM state and shared gap/timeout timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         timer_r <= TIMER_ZERO;
      end else begin
         state_r <= state_next;
         timer_r <= timer_next;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem[tail_r] <= order_type;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_r  <= PTR_ZERO;
         tail_r  <= PTR_ZERO;
         count_r <= COUNT_ZERO;
      end else begin
         count_r <= count_next;
         if (cancel_all) begin
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
         end else begin
            if (push_ok_s) begin
               tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
               head_r <= ptr_inc(head_r);
            end
         end
      end
   end

   // Registered status and handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         order_accept_r <= 1'b0;
         order_reject_r <= 1'b0;
         brew_start_r   <= 1'b0;
         brew_type_r    <= 2'd0;
         brew_busy_r    <= 1'b0;
         fault_r        <= 1'b0;
         served_r       <= 8'd0;
      end else begin
         order_accept_r <= push_ok_s;
         order_reject_r <= order_valid && !push_ok_s;
         brew_start_r   <= start_s;
         brew_busy_r    <= (state_next == ST_ISSUE) || (state_next == ST_BREWING);
         fault_r        <= (state_next == ST_FAULT);
         // Head is read before any same-edge write, so a full-FIFO push is safe.
         if (pop_s) begin
            brew_type_r <= fifo_mem[head_r];
         end
         if (served_inc_s) begin
            served_r <= served_r + 8'd1;
         end
      end
   end

   assign order_accept = order_accept_r;
   assign order_reject = order_reject_r;
   assign brew_start   = brew_start_r;
   assign brew_type    = brew_type_r;
   assign brew_busy    = brew_busy_r;
   assign fault        = fault_r;
   assign queue_count  = count_r;
   assign served_count = served_r;

endmodule

// File: tb/tb_brew_order_scheduler.sv
// -----------------------------------------------------------------------------
// tb_brew_order_scheduler
//
// Directed self-checking bench for brew_order_scheduler with DEPTH=4,
// GAP_CYCLES=3, TIMEOUT_CYCLES=10. Inputs change and outputs are sampled on
// the falling clock edge, so each sample shows the result of the preceding
// rising edge.
// -----------------------------------------------------------------------------
module tb_brew_order_scheduler;

   logic       clk;
   logic       reset;
   logic       order_valid;
   logic [1:0] order_type;
   logic       cancel_all;
   logic       clear_fault;
   logic       brew_done;
   logic       order_accept;
   logic       order_reject;
   logic       brew_start;
   logic [1:0] brew_type;
   logic       brew_busy;
   logic       fault;
   logic [2:0] queue_count;
   logic [7:0] served_count;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_types [4] = '{1, 2, 0, 1};

   brew_order_scheduler #(
      .DEPTH          (4),
      .GAP_CYCLES     (3),
      .TIMEOUT_CYCLES (10),
      .TIMER_W        (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .order_valid  (order_valid),
      .order_type   (order_type),
      .cancel_all   (cancel_all),
      .clear_fault  (clear_fault),
      .brew_done    (brew_done),
      .order_accept (order_accept),
      .order_reject (order_reject),
      .brew_start   (brew_start),
      .brew_type    (brew_type),
      .brew_busy    (brew_busy),
      .fault        (fault),
      .queue_count  (queue_count),
      .served_count (served_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run always terminates.
   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   task automatic push(input logic [1:0] t);
      order_valid = 1'b1;
      order_type  = t;
      tick();
      order_valid = 1'b0;
      order_type  = 2'd0;
   endtask

   task automatic done_pulse();
      brew_done = 1'b1;
      tick();
      brew_done = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while ((brew_start !== 1'b1) && (n < 30)) begin
         tick();
         n++;
      end
      check(tag, 32'(brew_start), 32'd1);
   endtask

   initial begin
      reset       = 1'b1;
      order_valid = 1'b0;
      order_type  = 2'd0;
      cancel_all  = 1'b0;
      clear_fault = 1'b0;
      brew_done   = 1'b0;
      cycles(2);
      check("rst_busy",   32'(brew_busy),    32'd0);
      check("rst_fault",  32'(fault),        32'd0);
      check("rst_qc",     32'(queue_count),  32'd0);
      check("rst_served", 32'(served_count), 32'd0);
      check("rst_start",  32'(brew_start),   32'd0);
      check("rst_type",   32'(brew_type),    32'd0);
      reset = 1'b0;
      tick();

      // 1: single order, latency, done, gap length
      push(2'd1);
      check("s1_accept", 32'(order_accept), 32'd1);
      check("s1_reject", 32'(order_reject), 32'd0);
      check("s1_qc1",    32'(queue_count),  32'd1);
      check("s1_nostart0", 32'(brew_start), 32'd0);
      tick();
      check("s1_issue_busy", 32'(brew_busy),   32'd1);
      check("s1_qc0",        32'(queue_count), 32'd0);
      check("s1_nostart1",   32'(brew_start),  32'd0);
      check("s1_accept_end", 32'(order_accept), 32'd0);
      tick();
      check("s1_start", 32'(brew_start), 32'd1);
      check("s1_type",  32'(brew_type),  32'd1);
      tick();
      check("s1_start_once", 32'(brew_start), 32'd0);
      cycles(3);
      done_pulse();
      check("s1_served", 32'(served_count), 32'd1);
      check("s1_idle_busy", 32'(brew_busy), 32'd0);
      push(2'd2);
      check("s1_gap_qc", 32'(queue_count), 32'd1);
      tick();
      check("s1_gap_busy_a", 32'(brew_busy), 32'd0);
      tick();
      check("s1_gap_busy_b", 32'(brew_busy), 32'd0);
      tick();
      check("s1_gap_over_busy", 32'(brew_busy), 32'd1);
      tick();
      check("s1_start2", 32'(brew_start), 32'd1);
      check("s1_type2",  32'(brew_type),  32'd2);
      done_pulse();
      check("s1_served2", 32'(served_count), 32'd2);
      cycles(3);

      // 2: five back-to-back orders, full queue, in-order dispatch
      push(2'd0);
      check("s2_acc0", 32'(order_accept), 32'd1);
      check("s2_qc0",  32'(queue_count),  32'd1);
      push(2'd1);
      check("s2_acc1",  32'(order_accept), 32'd1);
      check("s2_qc1",   32'(queue_count),  32'd1);
      check("s2_type0", 32'(brew_type),    32'd0);
      push(2'd2);
      check("s2_qc2",    32'(queue_count), 32'd2);
      check("s2_start0", 32'(brew_start),  32'd1);
      push(2'd0);
      check("s2_qc3", 32'(queue_count), 32'd3);
      push(2'd1);
      check("s2_acc4", 32'(order_accept), 32'd1);
      check("s2_qc4",  32'(queue_count),  32'd4);
      push(2'd2);
      check("s2_full_rej", 32'(order_reject), 32'd1);
      check("s2_full_acc", 32'(order_accept), 32'd0);
      check("s2_full_qc",  32'(queue_count),  32'd4);
      done_pulse();
      check("s2_served0", 32'(served_count), 32'd3);
      for (int i = 1; i <= 4; i++) begin
         wait_start("s2_wait_start");
         check("s2_type",   32'(brew_type),   32'(exp_types[i-1]));
         check("s2_qc_pop", 32'(queue_count), 32'(4 - i));
         done_pulse();
         check("s2_served", 32'(served_count), 32'(2 + 1 + i));
      end
      cycles(4);

      // 3 + 4: illegal type, timeout to FAULT, clear_fault resumes
      push(2'd2);
      check("s4_qc_a", 32'(queue_count), 32'd1);
      push(2'd0);
      check("s4_type", 32'(brew_type),   32'd2);
      check("s4_qc_b", 32'(queue_count), 32'd1);
      push(2'd1);
      check("s4_start", 32'(brew_start),  32'd1);
      check("s4_qc_c",  32'(queue_count), 32'd2);
      push(2'd3);
      check("s3_illegal_rej", 32'(order_reject), 32'd1);
      check("s3_illegal_acc", 32'(order_accept), 32'd0);
      check("s3_illegal_qc",  32'(queue_count),  32'd2);
      cycles(8);
      check("s4_pre_fault", 32'(fault),     32'd0);
      check("s4_pre_busy",  32'(brew_busy), 32'd1);
      tick();
      check("s4_fault",      32'(fault),       32'd1);
      check("s4_fault_busy", 32'(brew_busy),   32'd0);
      check("s4_fault_qc",   32'(queue_count), 32'd2);
      check("s4_fault_type", 32'(brew_type),   32'd2);
      done_pulse();
      check("s4_done_ignored", 32'(served_count), 32'd7);
      check("s4_fault_held",   32'(fault),        32'd1);
      push(2'd0);
      check("s4_fault_accept", 32'(order_accept), 32'd1);
      check("s4_fault_qc3",    32'(queue_count),  32'd3);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("s4_cleared", 32'(fault), 32'd0);
      tick();
      check("s4_resume_busy", 32'(brew_busy),   32'd1);
      check("s4_resume_type", 32'(brew_type),   32'd0);
      check("s4_resume_qc",   32'(queue_count), 32'd2);
      tick();
      check("s4_resume_start", 32'(brew_start), 32'd1);

      // 5: done on the timeout cycle wins
      cycles(9);
      check("s5_pre_fault", 32'(fault), 32'd0);
      done_pulse();
      check("s5_no_fault", 32'(fault),        32'd0);
      check("s5_served",   32'(served_count), 32'd8);
      check("s5_busy",     32'(brew_busy),    32'd0);

      // 6: cancel_all with a simultaneous order while brewing
      push(2'd2);
      check("s6_qc3a", 32'(queue_count), 32'd3);
      wait_start("s6_wait_start");
      check("s6_type", 32'(brew_type),   32'd1);
      check("s6_qc2",  32'(queue_count), 32'd2);
      push(2'd0);
      check("s6_qc3b", 32'(queue_count), 32'd3);
      order_valid = 1'b1;
      order_type  = 2'd1;
      cancel_all  = 1'b1;
      tick();
      order_valid = 1'b0;
      cancel_all  = 1'b0;
      check("s6_cancel_qc",   32'(queue_count),  32'd0);
      check("s6_cancel_rej",  32'(order_reject), 32'd1);
      check("s6_cancel_acc",  32'(order_accept), 32'd0);
      check("s6_cancel_busy", 32'(brew_busy),    32'd1);
      done_pulse();
      check("s6_served", 32'(served_count), 32'd9);
      cycles(6);
      check("s6_idle_busy", 32'(brew_busy),   32'd0);
      check("s6_idle_qc",   32'(queue_count), 32'd0);

      // 7: served_count wraps
      for (int i = 0; i < 246; i++) begin
         push(2'd0);
         wait_start("s7_wait_start");
         done_pulse();
      end
      check("s7_served255", 32'(served_count), 32'd255);
      push(2'd1);
      wait_start("s7_wait_last");
      done_pulse();
      check("s7_wrap", 32'(served_count), 32'd0);
      cycles(4);
      push(2'd1);
      wait_start("s7_wait_post");
      done_pulse();
      check("s7_served1", 32'(served_count), 32'd1);

      // Asynchronous reset in the middle of a brew
      cycles(4);
      push(2'd2);
      push(2'd1);
      wait_start("rst_wait_start");
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("amid_busy",   32'(brew_busy),    32'd0);
      check("amid_served", 32'(served_count), 32'd0);
      check("amid_qc",     32'(queue_count),  32'd0);
      check("amid_type",   32'(brew_type),    32'd0);
      tick();
      reset = 1'b0;
      cycles(3);
      check("amid_after_busy", 32'(brew_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
